// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and defaults for the instruction memory controller
package instr_mem_pkg;

    localparam int IMC_INSTR_W = 19;
    localparam int IMC_ADDR_W  = 12;
    localparam int IMC_DEPTH   = 4096;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } imc_state_t;

    typedef logic [IMC_INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = '0;

    // Address bits needed to index DEPTH words (at least one).
    function automatic int imc_ram_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imc_ram.sv
// rtl/imc_ram.sv - 1W/1R word array, synchronous read, read-before-write
//
// Ports:
//   clk    rising-edge clock
//   we     write enable; waddr/wdata written at the edge
//   waddr  write word address (must be < DEPTH)
//   wdata  write word
//   re     read enable; rdata updates at the edge, otherwise holds
//   raddr  read word address (must be < DEPTH)
//   rdata  registered read word; same-address write returns the old word
module imc_ram
    import instr_mem_pkg::*;
#(
    parameter int W     = IMC_INSTR_W,
    parameter int DEPTH = IMC_DEPTH,
    parameter int AW    = imc_ram_aw(IMC_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a read of the address being written
    // sees the value from before this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - instruction memory with zero-fill sweep, load port and held fetch port
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   init_done   1 once the post-reset zero-fill sweep has completed
//   ld_valid    load request; ld_ready accepts it (high in RUN)
//   ld_addr     load word address; addresses >= DEPTH are accepted and dropped
//   ld_data     load word
//   fetch_req   fetch request; fetch_rdy accepts it
//   fetch_addr  fetch word address
//   rsp_valid   response valid one cycle after accept
//   rsp_instr   fetched word (0 on error)
//   rsp_err     fetch address was >= DEPTH
//   rsp_hold    consumer stall; freezes a valid response and blocks new fetches
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int INSTR_W = IMC_INSTR_W,
    parameter int ADDR_W  = IMC_ADDR_W,
    parameter int DEPTH   = IMC_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_done,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               fetch_req,
    output logic               fetch_rdy,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               rsp_valid,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_err,
    input  logic               rsp_hold
);

    localparam int                RAM_AW  = imc_ram_aw(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    imc_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic               rsp_valid_q, rsp_err_q;

    logic               in_clear;
    logic               ld_in_range, fetch_in_range;
    logic               ld_fire, fetch_fire;
    logic               ram_we, ram_re;
    logic [RAM_AW-1:0]  ram_waddr;
    logic [INSTR_W-1:0] ram_wdata;
    logic [INSTR_W-1:0] ram_rdata;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // The sweep stops on the last word, so clr_ptr never wraps even when
    // DEPTH == 2**ADDR_W.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == LAST) begin
                    state_d = RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            RUN: begin
            end
            default: state_d = CLEAR;
        endcase
    end

    // ---------------- handshakes ----------------
    assign in_clear       = (state_q == CLEAR);
    assign init_done      = ~in_clear;
    assign ld_ready       = ~in_clear;
    assign fetch_rdy      = ~in_clear & ~(rsp_valid_q & rsp_hold);

    assign ld_in_range    = ({1'b0, ld_addr}    < DEPTH_X);
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);

    assign ld_fire        = ld_valid  & ld_ready;
    assign fetch_fire     = fetch_req & fetch_rdy;

    // ---------------- RAM port muxing ----------------
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (in_clear) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr_q[RAM_AW-1:0];
            ram_wdata = '0;
        end else if (ld_fire && ld_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = ld_addr[RAM_AW-1:0];
            ram_wdata = ld_data;
        end
    end

    // Reading only on an in-range accept keeps ram_rdata stable while a
    // response is held (no accept can happen then).
    assign ram_re = fetch_fire & fetch_in_range;

    imc_ram #(
        .W     (INSTR_W),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    // ---------------- response register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (rsp_valid_q && rsp_hold) begin
            rsp_valid_q <= rsp_valid_q;
            rsp_err_q   <= rsp_err_q;
        end else if (fetch_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~fetch_in_range;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end
    end

    // The RAM output is not reset, so it is masked to zero unless it
    // carries a valid in-range response.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_instr = (rsp_valid_q && !rsp_err_q) ? ram_rdata : INSTR_W'(NOP_INSTR);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - directed table-driven bench for instr_mem_ctrl
module tb_instr_mem_ctrl;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_done;
    logic               ld_valid;
    logic               ld_ready;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               fetch_req;
    logic               fetch_rdy;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_instr;
    logic               rsp_err;
    logic               rsp_hold;

    always #5 clk = ~clk;

    instr_mem_ctrl #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .fetch_req  (fetch_req),
        .fetch_rdy  (fetch_rdy),
        .fetch_addr (fetch_addr),
        .rsp_valid  (rsp_valid),
        .rsp_instr  (rsp_instr),
        .rsp_err    (rsp_err),
        .rsp_hold   (rsp_hold)
    );

    typedef struct {
        logic               ld_v;
        logic [ADDR_W-1:0]  ld_a;
        logic [INSTR_W-1:0] ld_d;
        logic               f_v;
        logic [ADDR_W-1:0]  f_a;
        logic               hold;
        logic               e_valid;
        logic [INSTR_W-1:0] e_instr;
        logic               e_err;
        logic               e_rdy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge with the
    // current inputs still applied.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic lv, input logic [ADDR_W-1:0] la, input logic [INSTR_W-1:0] ld,
                         input logic fv, input logic [ADDR_W-1:0] fa, input logic h);
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ld;
        fetch_req  = fv;
        fetch_addr = fa;
        rsp_hold   = h;
    endtask

    // Release reset and count cycles to init_done while poking both ports.
    task automatic run_clear(input string tag);
        int  n;
        bit  rdy_seen;
        n        = 0;
        rdy_seen = 1'b0;
        rst      = 1'b1;
        drive(1'b1, 5'd7, 19'h55555, 1'b1, 5'd7, 1'b0);
        while (n < 64) begin
            if (ld_ready || fetch_rdy) rdy_seen = 1'b1;
            step();
            n++;
            if (init_done) break;
        end
        chk({tag, "_clear_cycles"}, n, 16);
        chk({tag, "_rdy_during_clear"}, {31'd0, rdy_seen}, 0);
        chk({tag, "_rsp_during_clear"}, {31'd0, rsp_valid}, 0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        //          ld_v  ld_a   ld_d       f_v   f_a    hold  valid instr      err   rdy
        vecs[0]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd5,  1'b0, 1'b1, 19'h00000, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd7,  1'b0, 1'b1, 19'h00000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd7,  19'h00C66, 1'b0, 5'd0,  1'b0, 1'b0, 19'h00000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd7,  1'b0, 1'b1, 19'h00C66, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd3,  19'h1ABCD, 1'b1, 5'd3,  1'b0, 1'b1, 19'h00000, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd3,  1'b0, 1'b1, 19'h1ABCD, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd20, 1'b0, 1'b1, 19'h00000, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 5'd20, 19'h7FFFF, 1'b0, 5'd0,  1'b0, 1'b0, 19'h00000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd20, 1'b0, 1'b1, 19'h00000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 5'd15, 19'h12345, 1'b1, 5'd15, 1'b0, 1'b1, 19'h00000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd15, 1'b0, 1'b1, 19'h12345, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd16, 1'b0, 1'b1, 19'h00000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 5'd8,  19'h0ABCD, 1'b0, 5'd0,  1'b0, 1'b0, 19'h00000, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd7,  1'b0, 1'b1, 19'h00C66, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd8,  1'b1, 1'b1, 19'h00C66, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd8,  1'b1, 1'b1, 19'h00C66, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd8,  1'b1, 1'b1, 19'h00C66, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 5'd0,  19'h00000, 1'b1, 5'd8,  1'b0, 1'b1, 19'h0ABCD, 1'b0, 1'b1};

        // Reset state.
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        step();
        chk("rst_init_done", {31'd0, init_done}, 0);
        chk("rst_ld_ready",  {31'd0, ld_ready},  0);
        chk("rst_fetch_rdy", {31'd0, fetch_rdy}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_instr", {13'd0, rsp_instr}, 0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   0);

        run_clear("init");
        chk("run_ld_ready", {31'd0, ld_ready}, 1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ld_v, vecs[i].ld_a, vecs[i].ld_d, vecs[i].f_v, vecs[i].f_a, vecs[i].hold);
            step();
            chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_rsp_instr", i), {13'd0, rsp_instr}, {13'd0, vecs[i].e_instr});
            chk($sformatf("v%0d_rsp_err", i),   {31'd0, rsp_err},   {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d_fetch_rdy", i), {31'd0, fetch_rdy}, {31'd0, vecs[i].e_rdy});
        end

        // Idle after the last response: valid drops.
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        step();
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);

        // Reset while a response is held.
        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
        step();
        chk("prehold_rsp", {13'd0, rsp_instr}, 19'h00C66);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        step();
        chk("held_rsp_valid", {31'd0, rsp_valid}, 1);
        rst = 1'b0;
        step();
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("midrst_init_done", {31'd0, init_done}, 0);
        chk("midrst_fetch_rdy", {31'd0, fetch_rdy}, 0);
        run_clear("rerun");

        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
        step();
        chk("post_rst_valid", {31'd0, rsp_valid}, 1);
        chk("post_rst_instr", {13'd0, rsp_instr}, 0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
